block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
- Kernel-level scheduler between the device control register and the compute cores.
- On `start`, latches the thread count programmed into the DCR and splits it into blocks of THREADS_PER_BLOCK threads.
- Hands blocks to free cores in ascending core order, recycles each core through reset when it finishes, and raises `done` once every block has completed.

Parameters:
- NUM_CORES, 2, number of compute cores served.
- THREADS_PER_BLOCK, 4, threads per block; a power of two, between 1 and 128.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; kernel runs while high.
- thread_count  in  8  total threads, driven from the DCR `thread_count` output.
- core_done  in  NUM_CORES  per-core block-complete flag; ignored while that core's `core_start` is 0.
- core_start  out  NUM_CORES  per-core start; held high while a block is running on that core.
- core_reset  out  NUM_CORES  per-core reset; high means the core is free/idle.
- core_block_id  out  8*NUM_CORES  packed; core i's block id is at [8i+7:8i].
- core_thread_count  out  8*NUM_CORES  packed; threads in core i's block, at [8i+7:8i].
- done  out  1  kernel complete.

Behaviour:
- Reset (synchronous, takes effect at the next edge, also mid-run):
  - state=IDLE; `core_reset` all 1; `core_start` all 0.
  - `core_block_id` and `core_thread_count` all 0; `done`=0.
  - Internal counters (`total_blocks`, `dispatched`, `completed`, latched count) all 0.
- Block arithmetic: `total_blocks` = (`thread_count` + THREADS_PER_BLOCK - 1) / THREADS_PER_BLOCK, computed at 9 bits so 255+3 does not overflow. Internal counters are 8 bits.
- IDLE:
  - Holds `core_reset` all 1.
  - On an edge with `start`=1: latch `thread_count` and `total_blocks`; clear `dispatched` and `completed`.
  - If `total_blocks`=0, go to DONE and set `done`=1 at that edge. Otherwise go to RUN.
- RUN: each edge, evaluate cores in ascending index order using registered values.
  - Free core (`core_reset[i]`=1):
    - Always set `core_reset[i]`<=0.
    - If blocks remain (`dispatched` plus blocks already assigned earlier this cycle < `total_blocks`): `core_start[i]`<=1; `core_block_id[i]`<=next id.
    - `core_thread_count[i]`<= THREADS_PER_BLOCK, except for the last block, which gets latched count - id*THREADS_PER_BLOCK.
    - Several cores may be assigned in one cycle; each consumes consecutive ids.
  - Idle core (`core_reset[i]`=0 and `core_start[i]`=0): no blocks left to assign; it stays as is.
  - Finished core (`core_start[i]`=1 and `core_done[i]`=1):
    - `core_start[i]`<=0; `core_reset[i]`<=1.
    - `completed` increments by the number of cores finishing that cycle, so simultaneous completions all count.
    - The freed core becomes eligible for dispatch on the following edge.
  - When the registered `completed` equals `total_blocks`: go to DONE, set `done`<=1, and set `core_reset` all 1.
- DONE:
  - `done` stays 1 while `start`=1.
  - When `start`=0: go to IDLE and clear `done`.
- Latency: `start` sampled at edge N gives RUN at N+1; the first `core_start` rises at edge N+2. A core's `core_done` seen at edge M gives that core `core_reset`=1 after M and, if blocks remain, a new `core_start` after M+1.
- Changes to `thread_count` after latching are ignored until the next IDLE to RUN transition.
- `start` dropping during RUN is ignored; the kernel runs to completion and then waits in DONE.

Test Plan:
- Even split (TPB=4, NUM_CORES=2): `thread_count`=8, `start`=1 -> at N+2, `core_start`=2'b11, ids 0/1, counts 4/4; pulse both `core_done` -> `done`=1 two edges later.
- Partial last block: `thread_count`=10 -> blocks 0 and 1 dispatched first; core0 finishes -> one edge in reset, then block 2 on core0 with count 2; after all three finish -> `done`=1; core1 not redispatched.
- Zero threads: `thread_count`=0, `start`=1 -> `done`=1 one edge later; no `core_start` ever asserts; drop `start` -> `done`=0, state IDLE.
- Max count: `thread_count`=255 -> exactly 64 blocks with ids 0..63, last block count 3, `done` after 64 completions; no wrap to 0 blocks.
- Reset mid-run: during RUN with both cores busy, `reset`=1 for one cycle -> `core_reset`=all 1, `core_start`=0, `done`=0; a new `start` runs a fresh kernel from block 0.
- Latch check: change `thread_count` from 8 to 200 during RUN -> still exactly 2 blocks dispatched; simultaneous `core_done` on both cores -> `completed` goes up by 2 in one cycle.

Source files
------------

// File: rtl/block_dispatcher.sv
// Kernel scheduler: splits the latched thread count into fixed-size blocks and
// hands them to free cores in ascending order, recycling each core through reset.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               thread_count,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES-1:0]     core_reset,
    output logic [8*NUM_CORES-1:0]   core_block_id,
    output logic [8*NUM_CORES-1:0]   core_thread_count,
    output logic                     done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                     r_state;
    logic [7:0]                     r_count;
    logic [7:0]                     r_total;
    logic [7:0]                     r_dispatched;
    logic [7:0]                     r_completed;
    logic [NUM_CORES-1:0]           r_core_start;
    logic [NUM_CORES-1:0]           r_core_reset;
    logic [NUM_CORES-1:0][7:0]      r_block_id;
    logic [NUM_CORES-1:0][7:0]      r_thread_cnt;
    logic                           r_done;

    logic [8:0]                     w_total_blocks;
    logic [8:0]                     w_next_id;
    logic [NUM_CORES-1:0]           w_assign;
    logic [NUM_CORES-1:0][7:0]      w_assign_id;
    logic [NUM_CORES-1:0][7:0]      w_assign_cnt;
    logic [NUM_CORES-1:0]           w_finish;
    logic [7:0]                     w_finish_count;

    // Widened to 9 bits so a count of 255 rounds up without wrapping.
    assign w_total_blocks = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1))
                            / 9'(THREADS_PER_BLOCK);

    // Walk cores in index order, handing consecutive ids to free cores.
    always_comb begin
        w_next_id      = {1'b0, r_dispatched};
        w_assign       = '0;
        w_assign_id    = '0;
        w_assign_cnt   = '0;
        w_finish       = r_core_start & core_done;
        w_finish_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_assign_id[i] = w_next_id[7:0];
            if (w_next_id == {1'b0, r_total} - 9'd1)
                w_assign_cnt[i] = r_count - w_next_id[7:0] * 8'(THREADS_PER_BLOCK);
            else
                w_assign_cnt[i] = 8'(THREADS_PER_BLOCK);
            if (r_core_reset[i] && (w_next_id < {1'b0, r_total})) begin
                w_assign[i] = 1'b1;
                w_next_id   = w_next_id + 9'd1;
            end
            if (w_finish[i])
                w_finish_count = w_finish_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_total      <= '0;
            r_dispatched <= '0;
            r_completed  <= '0;
            r_core_start <= '0;
            r_core_reset <= '1;
            r_block_id   <= '0;
            r_thread_cnt <= '0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_core_reset <= '1;
                    r_core_start <= '0;
                    if (start) begin
                        r_count      <= thread_count;
                        r_total      <= w_total_blocks[7:0];
                        r_dispatched <= '0;
                        r_completed  <= '0;
                        if (w_total_blocks == 9'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_completed == r_total) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_core_reset <= '1;
                        r_core_start <= '0;
                    end else begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (r_core_reset[i]) begin
                                r_core_reset[i] <= 1'b0;
                                if (w_assign[i]) begin
                                    r_core_start[i] <= 1'b1;
                                    r_block_id[i]   <= w_assign_id[i];
                                    r_thread_cnt[i] <= w_assign_cnt[i];
                                end
                            end else if (w_finish[i]) begin
                                r_core_start[i] <= 1'b0;
                                r_core_reset[i] <= 1'b1;
                            end
                        end
                        r_dispatched <= w_next_id[7:0];
                        r_completed  <= r_completed + w_finish_count;
                    end
                end
                DONE: begin
                    r_core_reset <= '1;
                    r_core_start <= '0;
                    if (!start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_start        = r_core_start;
    assign core_reset        = r_core_reset;
    assign core_block_id     = r_block_id;
    assign core_thread_count = r_thread_cnt;
    assign done              = r_done;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with NUM_CORES=2, THREADS_PER_BLOCK=4.
module tb_block_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  threadCount;
    logic [1:0]  coreDone;
    logic [1:0]  coreStart;
    logic [1:0]  coreReset;
    logic [15:0] coreBlockId;
    logic [15:0] coreThreadCount;
    logic        done;

    int checks = 0;
    int errors = 0;
    int blocksSeen;
    logic [1:0] prevStart;

    block_dispatcher #(
        .NUM_CORES         (2),
        .THREADS_PER_BLOCK (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (threadCount),
        .core_done         (coreDone),
        .core_start        (coreStart),
        .core_reset        (coreReset),
        .core_block_id     (coreBlockId),
        .core_thread_count (coreThreadCount),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, then step one edge and settle just past it.
    task automatic applyStimulus(input logic s, input logic [7:0] tc, input logic [1:0] cd);
        start       = s;
        threadCount = tc;
        coreDone    = cd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 2'b00);
        applyStimulus(1'b0, 8'd0, 2'b00);
        reset = 1'b0;
        checkOutput("rstCoreReset", coreReset, 2'b11);
        checkOutput("rstCoreStart", coreStart, 2'b00);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstBlockId", coreBlockId, 16'h0000);
        checkOutput("rstThreadCnt", coreThreadCount, 16'h0000);

        // Even split: 8 threads -> two full blocks.
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("evenRunNoStart", coreStart, 2'b00);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("evenStart", coreStart, 2'b11);
        checkOutput("evenReset", coreReset, 2'b00);
        checkOutput("evenIds", coreBlockId, 16'h0100);
        checkOutput("evenCnts", coreThreadCount, 16'h0404);
        applyStimulus(1'b1, 8'd8, 2'b11);
        checkOutput("evenFinStart", coreStart, 2'b00);
        checkOutput("evenFinReset", coreReset, 2'b11);
        checkOutput("evenFinNotDone", done, 1'b0);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("evenDone", done, 1'b1);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("evenDoneHold", done, 1'b1);
        applyStimulus(1'b0, 8'd8, 2'b00);
        checkOutput("evenDoneClear", done, 1'b0);

        // Partial last block: 10 threads -> counts 4, 4, 2.
        applyStimulus(1'b1, 8'd10, 2'b00);
        applyStimulus(1'b1, 8'd10, 2'b00);
        checkOutput("partStart", coreStart, 2'b11);
        checkOutput("partIds", coreBlockId, 16'h0100);
        checkOutput("partCnts", coreThreadCount, 16'h0404);
        applyStimulus(1'b1, 8'd10, 2'b01);
        checkOutput("partC0Freed", coreStart, 2'b10);
        checkOutput("partC0Reset", coreReset, 2'b01);
        applyStimulus(1'b1, 8'd10, 2'b00);
        checkOutput("partRedispatch", coreStart, 2'b11);
        checkOutput("partIds2", coreBlockId, 16'h0102);
        checkOutput("partCnts2", coreThreadCount, 16'h0402);
        checkOutput("partReset2", coreReset, 2'b00);
        applyStimulus(1'b1, 8'd10, 2'b11);
        checkOutput("partFinStart", coreStart, 2'b00);
        checkOutput("partNotDone", done, 1'b0);
        applyStimulus(1'b1, 8'd10, 2'b00);
        checkOutput("partDone", done, 1'b1);
        checkOutput("partNoRedispatch", coreStart, 2'b00);
        applyStimulus(1'b0, 8'd10, 2'b00);
        checkOutput("partDoneClear", done, 1'b0);

        // Zero threads goes straight to done without dispatching.
        applyStimulus(1'b1, 8'd0, 2'b00);
        checkOutput("zeroDone", done, 1'b1);
        checkOutput("zeroNoStart", coreStart, 2'b00);
        applyStimulus(1'b1, 8'd0, 2'b00);
        checkOutput("zeroDoneHold", done, 1'b1);
        checkOutput("zeroNoStart2", coreStart, 2'b00);
        applyStimulus(1'b0, 8'd0, 2'b00);
        checkOutput("zeroDoneClear", done, 1'b0);
        checkOutput("zeroIdleReset", coreReset, 2'b11);
        applyStimulus(1'b0, 8'd0, 2'b00);
        checkOutput("zeroIdleStay", done, 1'b0);

        // Max count: 255 threads -> 64 blocks, last one holds 3 threads.
        applyStimulus(1'b1, 8'd255, 2'b00);
        blocksSeen = 0;
        prevStart  = 2'b00;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            applyStimulus(1'b1, 8'd255, coreStart);
            for (int i = 0; i < 2; i++) begin
                if (coreStart[i] && !prevStart[i]) begin
                    checkOutput("maxId", coreBlockId[8*i +: 8], blocksSeen);
                    checkOutput("maxCnt", coreThreadCount[8*i +: 8],
                                (blocksSeen == 63) ? 32'd3 : 32'd4);
                    blocksSeen++;
                end
            end
            prevStart = coreStart;
        end
        checkOutput("maxBlocks", blocksSeen, 64);
        checkOutput("maxDone", done, 1'b1);
        applyStimulus(1'b0, 8'd255, 2'b00);
        checkOutput("maxDoneClear", done, 1'b0);

        // Reset mid-run, then a fresh kernel starts from block 0.
        applyStimulus(1'b1, 8'd8, 2'b00);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("rstRunBusy", coreStart, 2'b11);
        reset = 1'b1;
        applyStimulus(1'b1, 8'd8, 2'b00);
        reset = 1'b0;
        checkOutput("midRstReset", coreReset, 2'b11);
        checkOutput("midRstStart", coreStart, 2'b00);
        checkOutput("midRstDone", done, 1'b0);
        checkOutput("midRstIds", coreBlockId, 16'h0000);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("freshRunNoStart", coreStart, 2'b00);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("freshStart", coreStart, 2'b11);
        checkOutput("freshIds", coreBlockId, 16'h0100);
        applyStimulus(1'b1, 8'd8, 2'b11);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("freshDone", done, 1'b1);
        applyStimulus(1'b0, 8'd8, 2'b00);

        // Thread count changed after latching must not add blocks.
        applyStimulus(1'b1, 8'd8, 2'b00);
        applyStimulus(1'b1, 8'd8, 2'b00);
        checkOutput("latchStart", coreStart, 2'b11);
        applyStimulus(1'b1, 8'd200, 2'b11);
        checkOutput("latchFinStart", coreStart, 2'b00);
        checkOutput("latchFinReset", coreReset, 2'b11);
        applyStimulus(1'b1, 8'd200, 2'b00);
        checkOutput("latchDone", done, 1'b1);
        checkOutput("latchNoExtra", coreStart, 2'b00);
        applyStimulus(1'b1, 8'd200, 2'b00);
        checkOutput("latchStillIdle", coreStart, 2'b00);
        applyStimulus(1'b0, 8'd200, 2'b00);
        checkOutput("latchDoneClear", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
